// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - 4-digit BCD capture and time-multiplexed active-low 7-segment driver
// The shadow holds the latest capture, and it is only copied to the display at the frame boundary.
module bcd_display_mux #(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1,
  parameter int DP_DIGIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_disp;
  logic          r_pending;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_frame_done;

  logic          w_tc;
  logic          w_boundary;
  logic [3:0]    w_digit;
  logic [3:0]    w_lz;
  logic          w_blank;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b0111111;
    endcase
  endfunction

  assign w_tc       = (r_presc == TC);
  assign w_boundary = w_tc && (r_idx == 2'd3);
  assign w_digit    = r_disp[{r_idx, 2'b00} +: 4];

  // w_lz[i]: digits 3..i are all zero
  assign w_lz[3] = (r_disp[15:12] == 4'd0);
  assign w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'd0);
  assign w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'd0);
  assign w_lz[0] = w_lz[1] && (r_disp[3:0] == 4'd0);

  assign w_blank = (BLANK_LZ != 0) && (r_idx != 2'd0) &&
                   (int'(r_idx) > DP_DIGIT) && w_lz[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A ready coinciding with the boundary bypasses the shadow and leaves nothing pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= 16'd0;
      r_pending <= 1'b0;
      r_disp    <= 16'd0;
    end else begin
      if (ready) r_shadow <= bcd;
      if (w_boundary) begin
        if (ready)          r_disp <= bcd;
        else if (r_pending) r_disp <= r_shadow;
        r_pending <= 1'b0;
      end else if (ready) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= 4'hF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= ~(4'b0001 << r_idx);
      r_seg        <= w_blank ? 7'h7F : f_seg(w_digit);
      r_dp         <= !(int'(r_idx) == DP_DIGIT);
      r_frame_done <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - randomized and directed checks of bcd_display_mux against a frame-level model
module tb_bcd_display_mux;
  localparam int SD   = 4;
  localparam int BLK  = 1;
  localparam int DPD  = 2;
  localparam int FRM  = 4 * SD;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'd0;
  logic        ready = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  bcd_display_mux #(.SCAN_DIV(SD), .BLANK_LZ(BLK), .DP_DIGIT(DPD)) dut (
    .clk(clk), .rst(rst), .bcd(bcd), .ready(ready),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n;
  logic [15:0] m_disp;
  logic [15:0] m_last;
  bit          m_pend;
  logic [6:0]  rec_seg [4];
  logic        rec_dp [4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [15:0] d, input int i);
    int v;
    int nib;
    v = int'(d) >> (4 * i);
    if (BLK != 0 && i != 0 && i > DPD && v == 0) return 7'h7F;
    nib = v & 15;
    if (nib > 9) return 7'b0111111;
    return SEG_TAB[nib];
  endfunction

  task automatic model_reset();
    n = 0;
    m_disp = 16'd0;
    m_last = 16'd0;
    m_pend = 0;
  endtask

  // Drive one cycle, advance the frame-level model, then compare all outputs after the edge.
  task automatic step(input logic rdy, input logic [15:0] val);
    int p, idx;
    bit bnd;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    ready = rdy;
    bcd = val;
    p = n % FRM;
    idx = p / SD;
    bnd = (p == FRM - 1);
    e_an = ~(4'b0001 << idx);
    e_seg = model_seg(m_disp, idx);
    e_dp = (idx == DPD) ? 1'b0 : 1'b1;
    if (bnd) begin
      if (rdy) m_disp = val;
      else if (m_pend) m_disp = m_last;
      m_pend = 0;
    end else if (rdy) begin
      m_last = val;
      m_pend = 1;
    end
    n++;
    @(posedge clk);
    #1;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
    check("frame_done", 16'(frame_done), 16'(bnd));
    rec_seg[idx] = seg;
    rec_dp[idx] = dp;
  endtask

  task automatic idle(input int cnt);
    for (int k = 0; k < cnt; k++) step(1'b0, 16'd0);
  endtask

  task automatic run_to(input int pos);
    while (n % FRM != pos) step(1'b0, 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 16'(an), 16'hF);
    check({tag, "_seg"}, 16'(seg), 16'h7F);
    check({tag, "_dp"}, 16'(dp), 16'h1);
    check({tag, "_fd"}, 16'(frame_done), 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;

    step(1'b0, 16'd0);
    check("first_an", 16'(an), 16'(4'b1110));
    check("first_seg", 16'(seg), 16'(7'b1000000));
    idle(2 * FRM - 1);

    run_to(0);
    step(1'b1, 16'h0042);
    run_to(0);
    idle(FRM);
    check("lz_d3", 16'(rec_seg[3]), 16'h7F);
    check("lz_d2", 16'(rec_seg[2]), 16'(7'b1000000));
    check("lz_d2_dp", 16'(rec_dp[2]), 16'h0);
    check("lz_d1", 16'(rec_seg[1]), 16'(7'b0011001));
    check("lz_d0", 16'(rec_seg[0]), 16'(7'b0100100));

    step(1'b1, 16'h1234);
    idle(6);
    step(1'b1, 16'h5678);
    run_to(0);
    idle(FRM);
    check("tear_d3", 16'(rec_seg[3]), 16'(7'b0010010));
    check("tear_d0", 16'(rec_seg[0]), 16'(7'b0000000));

    run_to(FRM - 1);
    step(1'b1, 16'h0009);
    check("coinc_fd", 16'(frame_done), 16'h1);
    idle(FRM);
    check("coinc_d0", 16'(rec_seg[0]), 16'(7'b0010000));
    check("coinc_d1", 16'(rec_seg[1]), 16'(7'b1000000));
    check("coinc_d3", 16'(rec_seg[3]), 16'h7F);

    step(1'b1, 16'hA000);
    run_to(0);
    idle(FRM);
    check("dash_d3", 16'(rec_seg[3]), 16'(7'b0111111));
    check("dash_d2", 16'(rec_seg[2]), 16'(7'b1000000));
    check("dash_d1", 16'(rec_seg[1]), 16'(7'b1000000));
    check("dash_d0", 16'(rec_seg[0]), 16'(7'b1000000));

    for (int k = 0; k < 600; k++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = v & 16'h00FF;
      step($urandom_range(0, 5) == 0, v);
    end

    run_to(8);
    step(1'b1, 16'h4321);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("async_hold");
    rst = 1'b0;
    model_reset();
    step(1'b0, 16'd0);
    check("rest_an", 16'(an), 16'(4'b1110));
    idle(FRM + 3);
    check("rest_d0", 16'(rec_seg[0]), 16'(7'b1000000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Downstream consumer of the stopwatch binary-to-BCD converter.
- Captures the 16-bit packed BCD word (4 digits) whenever the converter flags ready, and holds it tear-free.
- Time-multiplexes the 4 digits onto one active-low 7-segment bus with active-low digit anodes.
- Adds leading-zero blanking, a fixed decimal point and an invalid-digit indicator.

Parameters:
- SCAN_DIV, 1000, clocks per digit slot (legal range ≥2).
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.
- DP_DIGIT, 2, digit index (0..3) whose decimal point is lit; 4 = no DP.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bcd  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- ready  input  1  qualifier: bcd is valid and new when ready=1 at a rising edge.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low, one-hot-low; an[i] drives digit i.
- frame_done  output  1  one-cycle pulse at each display-register update boundary.

Behaviour:
- Reset (async assert) sets: shadow=0, pending=0, disp=0, prescaler=0, idx=0, seg=7'h7F, dp=1, an=4'hF, frame_done=0.
- Capture: ready=1 at an edge loads shadow<=bcd and sets pending=1. Multiple readies within a frame keep only the last value. ready held high for consecutive cycles captures every cycle.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. At terminal count, idx<=idx+1 mod 4.
- Frame boundary = terminal count with idx==3.
  - If pending=1: disp<=shadow and pending<=0.
  - If ready=1 on the same edge: disp<=bcd directly (bypass) and pending stays 0.
  - frame_done=1 for exactly that cycle, regardless of whether pending was set.
- Outputs are registered from the current idx and disp, one cycle behind idx.
  - First edge after reset release: an=4'b1110 and digit-0 pattern.
  - an is never all-low and never has two bits low.
- Digit d = disp[4i+3:4i].
- Encoding (seg, active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash, g only).
- Blanking, when BLANK_LZ=1:
  - Digit i is blanked (seg=7'h7F) iff digits 3..i are all zero AND i>DP_DIGIT AND i≠0.
  - Digit 0 is never blanked.
  - A dash counts as non-zero and stops blanking.
- dp=0 iff idx==DP_DIGIT. dp is not affected by blanking.
- Reset mid-scan: all state returns to reset values immediately (asynchronously). Any pending capture is lost.

Test Plan:
- Reset: SCAN_DIV=4, rst held then released, no ready.
  - an=1111, seg=7F during reset.
  - First edge after release: an=1110, seg=1000000.
  - an then sequences 1110→1101→1011→0111 every 4 clocks.
  - frame_done pulses every 16 clocks.
- Capture and blanking: ready pulse with bcd=16'h0042, BLANK_LZ=1, DP_DIGIT=2.
  - After the next frame boundary: digit3 blank; digit2 shows 0 with dp=0 (not blanked since i≤DP_DIGIT); digit1=0011001; digit0=0100100.
- Tear-free update: ready with 16'h1234 mid-frame, then ready with 16'h5678 before the boundary.
  - disp goes straight from old value to 5678; 1234 never appears on any digit.
- Coincident events: ready with 16'h0009 on the exact boundary edge.
  - disp=0009 in that edge; frame_done=1; pending=0 afterwards.
- Invalid digit: bcd=16'hA000, BLANK_LZ=1.
  - Digit3 shows dash 0111111; digits 2..0 show 0 (not blanked).
- Async reset mid-scan: assert rst between edges while idx=2 with pending=1.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, disp=0 and the scan restarts at digit 0.
